// File: rtl/pmem_arb_pkg.sv
// Shared types and sizes for the two-client physical-memory arbiter.
package pmem_arb_pkg;

  localparam int unsigned PMEM_ADDR_W   = 16;
  localparam int unsigned PMEM_LINE_W   = 128;
  localparam int unsigned PMEM_OFFSET_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    GAP     = 2'd3
  } state_e;

  typedef enum logic {
    CLIENT_I = 1'b0,
    CLIENT_D = 1'b1
  } client_e;

endpackage

// File: rtl/pmem_arb_grant.sv
// Grant select for the two memory clients.
// Policy macro: PMEM_ARB_ROUND_ROBIN_EN selects alternating grants on a tie;
// without it the data client always wins a tie.
module pmem_arb_grant
  import pmem_arb_pkg::*;
(
  input  logic    i_req,
  input  logic    d_req,
`ifdef PMEM_ARB_ROUND_ROBIN_EN
  input  client_e pref,
`endif
  output client_e grant
);

  // Pick the winner from the two request bits (and the tie preference).
  always_comb begin
    grant = CLIENT_I;
`ifdef PMEM_ARB_ROUND_ROBIN_EN
    if (i_req && d_req) begin
      grant = pref;
    end else if (d_req) begin
      grant = CLIENT_D;
    end
`else
    if (d_req) begin
      grant = CLIENT_D;
    end
`endif
  end

endmodule

// File: rtl/pmem_arbiter.sv
// Two-client initiator for the 128-bit line physical memory. Grants one client
// at a time, forwards its request, routes the response back, and inserts one
// idle cycle (GAP) after each transaction.
// Policy macro: PMEM_ARB_ROUND_ROBIN_EN (alternating tie-break); undefined
// gives fixed data-over-instruction priority.
module pmem_arbiter
  import pmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = PMEM_ADDR_W,
  parameter int unsigned LINE_W = PMEM_LINE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic              i_write,
  input  logic [ADDR_W-1:0] i_address,
  input  logic [LINE_W-1:0] i_wdata,
  output logic              i_resp,
  output logic [LINE_W-1:0] i_rdata,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic              d_resp,
  output logic [LINE_W-1:0] d_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic              mem_resp,
  input  logic [LINE_W-1:0] mem_rdata
);

  state_e  state_reg, state_next;
  client_e grant_reg;
  client_e grant_sel;
  logic    i_req, d_req, take;

  assign i_req = i_read | i_write;
  assign d_req = d_read | d_write;
  assign take  = (state_reg == IDLE) && (i_req || d_req);

`ifdef PMEM_ARB_ROUND_ROBIN_EN
  // Holds the client that wins the next tie, i.e. the one not granted last.
  // It resets to data so the first contention after reset goes to data.
  client_e last_reg;

  pmem_arb_grant u_grant (
    .i_req (i_req),
    .d_req (d_req),
    .pref  (last_reg),
    .grant (grant_sel)
  );

  // Flip the tie preference away from whoever was just granted.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_reg <= CLIENT_D;
    end else if (take) begin
      last_reg <= (grant_sel == CLIENT_D) ? CLIENT_I : CLIENT_D;
    end
  end
`else
  pmem_arb_grant u_grant (
    .i_req (i_req),
    .d_req (d_req),
    .grant (grant_sel)
  );
`endif

  // State and grant registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      grant_reg <= CLIENT_I;
    end else begin
      state_reg <= state_next;
      if (take) begin
        grant_reg <= grant_sel;
      end
    end
  end

  // Next state, memory strobes/fields and response routing.
  always_comb begin
    state_next  = state_reg;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    i_resp      = 1'b0;
    d_resp      = 1'b0;
    mem_address = (grant_reg == CLIENT_D) ? d_address : i_address;
    mem_wdata   = (grant_reg == CLIENT_D) ? d_wdata : i_wdata;
    case (state_reg)
      IDLE: begin
        if (take) begin
          state_next = (grant_sel == CLIENT_D) ? SERVE_D : SERVE_I;
        end
      end
      SERVE_I: begin
        // Read+write together is illegal; only the write is forwarded.
        mem_write = i_write;
        mem_read  = i_read & ~i_write;
        i_resp    = mem_resp;
        if (mem_resp) begin
          state_next = GAP;
        end
      end
      SERVE_D: begin
        mem_write = d_write;
        mem_read  = d_read & ~d_write;
        d_resp    = mem_resp;
        if (mem_resp) begin
          state_next = GAP;
        end
      end
      GAP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Directed self-checking bench for pmem_arbiter.
// Honours PMEM_ARB_ROUND_ROBIN_EN when choosing the expected contention order.
module tb_pmem_arbiter;
  import pmem_arb_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_read, i_write, d_read, d_write;
  logic [15:0]  i_address, d_address;
  logic [127:0] i_wdata, d_wdata;
  logic         i_resp, d_resp;
  logic [127:0] i_rdata, d_rdata;
  logic         mem_read, mem_write;
  logic [15:0]  mem_address;
  logic [127:0] mem_wdata;
  logic         mem_resp;
  logic [127:0] mem_rdata;

  int pass_cnt  = 0;
  int check_cnt = 0;

  logic exp_d [4];

  pmem_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .i_read      (i_read),
    .i_write     (i_write),
    .i_address   (i_address),
    .i_wdata     (i_wdata),
    .i_resp      (i_resp),
    .i_rdata     (i_rdata),
    .d_read      (d_read),
    .d_write     (d_write),
    .d_address   (d_address),
    .d_wdata     (d_wdata),
    .d_resp      (d_resp),
    .d_rdata     (d_rdata),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_address (mem_address),
    .mem_wdata   (mem_wdata),
    .mem_resp    (mem_resp),
    .mem_rdata   (mem_rdata)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    check_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  initial begin
    rst = 1'b1;
    i_read = 0; i_write = 0; d_read = 0; d_write = 0;
    i_address = '0; d_address = '0; i_wdata = '0; d_wdata = '0;
    mem_resp = 0; mem_rdata = '0;
`ifdef PMEM_ARB_ROUND_ROBIN_EN
    exp_d[0] = 1; exp_d[1] = 0; exp_d[2] = 1; exp_d[3] = 0;
`else
    exp_d[0] = 1; exp_d[1] = 1; exp_d[2] = 1; exp_d[3] = 1;
`endif

    // Reset state
    cyc();
    cyc();
    #1;
    chk("rst_state", 128'(dut.state_reg), 128'(IDLE));
    chk("rst_mem_read", mem_read, 1'b0);
    chk("rst_mem_write", mem_write, 1'b0);
    chk("rst_resps", {i_resp, d_resp}, 2'b00);
    rst = 0;
    cyc();

    // Single data read
    d_read = 1; d_address = 16'h0040;
    #1 chk("rd_idle_mem_read", mem_read, 1'b0);
    cyc();
    #1 chk("rd_mem_read", mem_read, 1'b1);
    chk("rd_mem_write", mem_write, 1'b0);
    chk("rd_mem_address", mem_address, 16'h0040);
    chk("rd_d_resp_pre", d_resp, 1'b0);
    mem_resp = 1; mem_rdata = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    #1 chk("rd_d_resp", d_resp, 1'b1);
    chk("rd_i_resp", i_resp, 1'b0);
    chk("rd_d_rdata", d_rdata, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
    cyc();
    d_read = 0; mem_resp = 0;
    #1 chk("rd_gap_state", 128'(dut.state_reg), 128'(GAP));
    chk("rd_gap_mem_read", mem_read, 1'b0);
    cyc();

    // Instruction write forward
    i_write = 1; i_address = 16'h1230; i_wdata = {16{8'hA5}};
    cyc();
    #1 chk("wr_mem_write", mem_write, 1'b1);
    chk("wr_mem_read", mem_read, 1'b0);
    chk("wr_mem_address", mem_address, 16'h1230);
    chk("wr_mem_wdata", mem_wdata, {16{8'hA5}});
    mem_resp = 1;
    #1 chk("wr_i_resp", i_resp, 1'b1);
    chk("wr_d_resp", d_resp, 1'b0);
    cyc();
    i_write = 0; mem_resp = 0;
    cyc();

    // Illegal read+write: only the write goes out
    i_read = 1; i_write = 1; i_address = 16'h0F00;
    cyc();
    #1 chk("rw_mem_write", mem_write, 1'b1);
    chk("rw_mem_read", mem_read, 1'b0);
    mem_resp = 1;
    cyc();
    i_read = 0; i_write = 0; mem_resp = 0;
    cyc();

    // Contention, D drops after its turn: D first, 2 idle cycles, then I
    i_read = 1; d_read = 1; i_address = 16'h0300; d_address = 16'h0400;
    cyc();
    #1 chk("ct_first_addr", mem_address, 16'h0400);
    chk("ct_first_read", mem_read, 1'b1);
    mem_resp = 1;
    #1 chk("ct_first_d_resp", d_resp, 1'b1);
    chk("ct_first_i_resp", i_resp, 1'b0);
    cyc();
    d_read = 0; mem_resp = 0;
    #1 chk("ct_gap_read", mem_read, 1'b0);
    cyc();
    #1 chk("ct_idle_read", mem_read, 1'b0);
    cyc();
    #1 chk("ct_second_read", mem_read, 1'b1);
    chk("ct_second_addr", mem_address, 16'h0300);
    mem_resp = 1;
    #1 chk("ct_second_i_resp", i_resp, 1'b1);
    cyc();
    i_read = 0; mem_resp = 0;
    cyc();

    // Continuous contention for 4 transactions
    i_read = 1; d_read = 1; i_address = 16'h0100; d_address = 16'h0200;
    for (int t = 0; t < 4; t++) begin
      #1 chk($sformatf("cc%0d_idle_read", t), mem_read, 1'b0);
      cyc();
      #1 chk($sformatf("cc%0d_addr", t), mem_address, exp_d[t] ? 16'h0200 : 16'h0100);
      chk($sformatf("cc%0d_read", t), mem_read, 1'b1);
      mem_resp = 1;
      #1 chk($sformatf("cc%0d_resp", t), {d_resp, i_resp}, exp_d[t] ? 2'b10 : 2'b01);
      $display("contention txn %0d granted %s", t, d_resp ? "D" : "I");
      cyc();
      mem_resp = 0;
      #1 chk($sformatf("cc%0d_gap_read", t), mem_read, 1'b0);
      cyc();
    end
    i_read = 0; d_read = 0;
    cyc();

    // Stray response in IDLE
    mem_resp = 1;
    #1 chk("stray_resps", {i_resp, d_resp}, 2'b00);
    cyc();
    mem_resp = 0;
    #1 chk("stray_state", 128'(dut.state_reg), 128'(IDLE));

    // Reset in the middle of SERVE_D
    d_read = 1; d_address = 16'h0880;
    cyc();
    #1 chk("mid_serve_read", mem_read, 1'b1);
    rst = 1;
    cyc();
    rst = 0; d_read = 0;
    #1 chk("mid_rst_state", 128'(dut.state_reg), 128'(IDLE));
    chk("mid_rst_strobes", {mem_read, mem_write}, 2'b00);
    cyc();
    mem_resp = 1;
    #1 chk("mid_stale_d_resp", d_resp, 1'b0);
    cyc();
    mem_resp = 0;
    #1 chk("mid_stale_state", 128'(dut.state_reg), 128'(IDLE));

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
